// File: rtl/cpu_pkg.sv
// cpu_pkg: control-word layout, ALUOp encodings and bubble constant shared by the pipeline.
package cpu_pkg;
  localparam int CTRL_W = 7;
  localparam int CTRL_REGWRITE = 6;
  localparam int CTRL_MEMTOREG = 5;
  localparam int CTRL_MEMREAD = 4;
  localparam int CTRL_MEMWRITE = 3;
  localparam int CTRL_ALUSRC = 2;
  localparam int CTRL_ALUOP_HI = 1;
  localparam int CTRL_ALUOP_LO = 0;
  typedef enum logic [1:0] {
    ALUOP_LDST   = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_RTYPE  = 2'b10,
    ALUOP_ITYPE  = 2'b11
  } aluop_e;
  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;
endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: ID-side inputs and EX-side outputs of the ID/EX register.
interface id_ex_stage_if
  import cpu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W = 32
);
  logic              stall_i;
  logic              flush_i;
  logic              id_valid_i;
  logic [CTRL_W-1:0] id_ctrl_i;
  logic [XLEN-1:0]   id_rs1_data_i;
  logic [XLEN-1:0]   id_rs2_data_i;
  logic [XLEN-1:0]   id_imm_i;
  logic [9:0]        id_funct_i;
  logic [REG_AW-1:0] id_rs1_i;
  logic [REG_AW-1:0] id_rs2_i;
  logic [REG_AW-1:0] id_rd_i;
  logic              ex_valid_o;
  logic [CTRL_W-1:0] ex_ctrl_o;
  logic [XLEN-1:0]   ex_rs1_data_o;
  logic [XLEN-1:0]   ex_rs2_data_o;
  logic [XLEN-1:0]   ex_imm_o;
  logic [9:0]        ex_funct_o;
  logic [REG_AW-1:0] ex_rs1_o;
  logic [REG_AW-1:0] ex_rs2_o;
  logic [REG_AW-1:0] ex_rd_o;
  logic              hazard_stall_o;
  logic [CNT_W-1:0]  bubble_cnt_o;
  modport master (
    output stall_i, flush_i, id_valid_i, id_ctrl_i, id_rs1_data_i, id_rs2_data_i,
           id_imm_i, id_funct_i, id_rs1_i, id_rs2_i, id_rd_i,
    input  ex_valid_o, ex_ctrl_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o, ex_funct_o,
           ex_rs1_o, ex_rs2_o, ex_rd_o, hazard_stall_o, bubble_cnt_o
  );
  modport slave (
    input  stall_i, flush_i, id_valid_i, id_ctrl_i, id_rs1_data_i, id_rs2_data_i,
           id_imm_i, id_funct_i, id_rs1_i, id_rs2_i, id_rd_i,
    output ex_valid_o, ex_ctrl_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o, ex_funct_o,
           ex_rs1_o, ex_rs2_o, ex_rd_o, hazard_stall_o, bubble_cnt_o
  );
endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// hazard_detect: load-use comparator; also usable by PC / IF-ID hold logic.
module hazard_detect #(
  parameter int REG_AW = 5
) (
  input  logic              i_ex_valid,
  input  logic              i_ex_memread,
  input  logic [REG_AW-1:0] i_ex_rd,
  input  logic              i_id_valid,
  input  logic [REG_AW-1:0] i_id_rs1,
  input  logic [REG_AW-1:0] i_id_rs2,
  input  logic              i_stall,
  input  logic              i_flush,
  output logic              o_hazard
);
  logic w_match;
  assign w_match  = (i_ex_rd != '0) && ((i_ex_rd == i_id_rs1) || (i_ex_rd == i_id_rs2));
  // Flush and stall both suppress the hold request: flush discards ID anyway, stall freezes all.
  assign o_hazard = i_ex_valid && i_ex_memread && i_id_valid && w_match && !i_flush && !i_stall;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubble insertion and bubble counter.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W = 32
) (
  input logic          clk_i,
  input logic          rst_i,
  id_ex_stage_if.slave bus
);
  logic              r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic [XLEN-1:0]   r_rs1_data;
  logic [XLEN-1:0]   r_rs2_data;
  logic [XLEN-1:0]   r_imm;
  logic [9:0]        r_funct;
  logic [REG_AW-1:0] r_rs1;
  logic [REG_AW-1:0] r_rs2;
  logic [REG_AW-1:0] r_rd;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_hazard;
  hazard_detect #(.REG_AW(REG_AW)) u_hazard (
    .i_ex_valid  (r_valid),
    .i_ex_memread(r_ctrl[CTRL_MEMREAD]),
    .i_ex_rd     (r_rd),
    .i_id_valid  (bus.id_valid_i),
    .i_id_rs1    (bus.id_rs1_i),
    .i_id_rs2    (bus.id_rs2_i),
    .i_stall     (bus.stall_i),
    .i_flush     (bus.flush_i),
    .o_hazard    (w_hazard)
  );
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_valid    <= 1'b0;
      r_ctrl     <= CTRL_BUBBLE;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_funct    <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_cnt      <= '0;
    end else if (!bus.stall_i) begin
      if (bus.flush_i || w_hazard) begin
        r_valid    <= 1'b0;
        r_ctrl     <= CTRL_BUBBLE;
        r_rs1_data <= '0;
        r_rs2_data <= '0;
        r_imm      <= '0;
        r_funct    <= '0;
        r_rs1      <= '0;
        r_rs2      <= '0;
        r_rd       <= '0;
        r_cnt      <= w_hazard ? r_cnt + 1'b1 : r_cnt;
      end else begin
        r_valid    <= bus.id_valid_i;
        r_ctrl     <= bus.id_valid_i ? bus.id_ctrl_i : CTRL_BUBBLE;
        r_rs1_data <= bus.id_rs1_data_i;
        r_rs2_data <= bus.id_rs2_data_i;
        r_imm      <= bus.id_imm_i;
        r_funct    <= bus.id_funct_i;
        r_rs1      <= bus.id_rs1_i;
        r_rs2      <= bus.id_rs2_i;
        r_rd       <= bus.id_rd_i;
      end
    end
  end
  assign bus.ex_valid_o     = r_valid;
  assign bus.ex_ctrl_o      = r_ctrl;
  assign bus.ex_rs1_data_o  = r_rs1_data;
  assign bus.ex_rs2_data_o  = r_rs2_data;
  assign bus.ex_imm_o       = r_imm;
  assign bus.ex_funct_o     = r_funct;
  assign bus.ex_rs1_o       = r_rs1;
  assign bus.ex_rs2_o       = r_rs2;
  assign bus.ex_rd_o        = r_rd;
  assign bus.hazard_stall_o = w_hazard;
  assign bus.bubble_cnt_o   = r_cnt;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed checks of the ID/EX register, hazard bubbles, flush and stall.
module tb_id_ex_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  localparam logic [6:0] C_LW  = 7'b1110100;
  localparam logic [6:0] C_ADD = 7'b1000010;
  id_ex_stage_if #(.XLEN(32), .REG_AW(5), .CNT_W(32)) bus ();
  id_ex_stage #(.XLEN(32), .REG_AW(5), .CNT_W(32)) dut (
    .clk_i(clk),
    .rst_i(rst_n),
    .bus  (bus.slave)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic id_set(input logic v, input logic [6:0] c, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] imm);
    bus.id_valid_i    = v;
    bus.id_ctrl_i     = c;
    bus.id_rs1_i      = rs1;
    bus.id_rs2_i      = rs2;
    bus.id_rd_i       = rd;
    bus.id_imm_i      = imm;
    bus.id_rs1_data_i = {27'd0, rs1} + 32'hA000_0000;
    bus.id_rs2_data_i = {27'd0, rs2} + 32'hB000_0000;
    bus.id_funct_i    = {5'd0, rd};
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.stall_i = 1'b0;
    bus.flush_i = 1'b0;
    id_set(1'b1, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), $urandom);
    step();
    id_set(1'b1, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), $urandom);
    step();
    chk("rst_valid", 64'(bus.ex_valid_o), 64'd0);
    chk("rst_ctrl", 64'(bus.ex_ctrl_o), 64'd0);
    chk("rst_rd", 64'(bus.ex_rd_o), 64'd0);
    chk("rst_imm", 64'(bus.ex_imm_o), 64'd0);
    chk("rst_data", 64'(bus.ex_rs1_data_o), 64'd0);
    chk("rst_cnt", 64'(bus.bubble_cnt_o), 64'd0);
    chk("rst_hazard", 64'(bus.hazard_stall_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    id_set(1'b1, C_ADD, 5'd1, 5'd2, 5'd3, 32'hFFFF_FFF8);
    step();
    chk("load_ctrl", 64'(bus.ex_ctrl_o), 64'(C_ADD));
    chk("load_rd", 64'(bus.ex_rd_o), 64'd3);
    chk("load_imm", 64'(bus.ex_imm_o), 64'hFFFF_FFF8);
    chk("load_valid", 64'(bus.ex_valid_o), 64'd1);
    chk("load_rs2data", 64'(bus.ex_rs2_data_o), 64'hB000_0002);
    chk("load_funct", 64'(bus.ex_funct_o), 64'd3);
    id_set(1'b0, C_ADD, 5'd4, 5'd5, 5'd6, 32'd7);
    step();
    chk("inv_valid", 64'(bus.ex_valid_o), 64'd0);
    chk("inv_ctrl", 64'(bus.ex_ctrl_o), 64'd0);
    chk("inv_rd", 64'(bus.ex_rd_o), 64'd6);
    id_set(1'b1, C_LW, 5'd1, 5'd0, 5'd5, 32'd4);
    step();
    id_set(1'b1, C_ADD, 5'd5, 5'd6, 5'd7, 32'd0);
    #1;
    chk("lu_hazard", 64'(bus.hazard_stall_o), 64'd1);
    step();
    chk("lu_bubble_valid", 64'(bus.ex_valid_o), 64'd0);
    chk("lu_bubble_ctrl", 64'(bus.ex_ctrl_o), 64'd0);
    chk("lu_cnt", 64'(bus.bubble_cnt_o), 64'd1);
    chk("lu_hazard_off", 64'(bus.hazard_stall_o), 64'd0);
    step();
    chk("lu_add_rd", 64'(bus.ex_rd_o), 64'd7);
    chk("lu_add_valid", 64'(bus.ex_valid_o), 64'd1);
    chk("lu_add_hazard", 64'(bus.hazard_stall_o), 64'd0);
    id_set(1'b1, C_LW, 5'd1, 5'd2, 5'd0, 32'd0);
    step();
    id_set(1'b1, C_ADD, 5'd0, 5'd0, 5'd8, 32'd0);
    #1;
    chk("x0_hazard", 64'(bus.hazard_stall_o), 64'd0);
    id_set(1'b1, C_LW, 5'd1, 5'd2, 5'd5, 32'd0);
    step();
    id_set(1'b1, C_ADD, 5'd6, 5'd7, 5'd8, 32'd0);
    #1;
    chk("nodep_hazard", 64'(bus.hazard_stall_o), 64'd0);
    step();
    chk("nodep_cnt", 64'(bus.bubble_cnt_o), 64'd1);
    chk("nodep_rd", 64'(bus.ex_rd_o), 64'd8);
    id_set(1'b1, C_LW, 5'd1, 5'd2, 5'd5, 32'd0);
    step();
    id_set(1'b1, C_ADD, 5'd5, 5'd2, 5'd9, 32'd0);
    bus.flush_i = 1'b1;
    #1;
    chk("flush_hazard", 64'(bus.hazard_stall_o), 64'd0);
    step();
    chk("flush_valid", 64'(bus.ex_valid_o), 64'd0);
    chk("flush_ctrl", 64'(bus.ex_ctrl_o), 64'd0);
    chk("flush_cnt", 64'(bus.bubble_cnt_o), 64'd1);
    bus.flush_i = 1'b0;
    id_set(1'b1, C_ADD, 5'd1, 5'd2, 5'd9, 32'h1234_5678);
    step();
    chk("pre_stall_rd", 64'(bus.ex_rd_o), 64'd9);
    bus.stall_i = 1'b1;
    bus.flush_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      id_set(1'b1, C_LW, 5'(i + 10), 5'd9, 5'(i + 20), 32'(i));
      step();
      chk("stall_rd", 64'(bus.ex_rd_o), 64'd9);
      chk("stall_imm", 64'(bus.ex_imm_o), 64'h1234_5678);
      chk("stall_valid", 64'(bus.ex_valid_o), 64'd1);
      chk("stall_cnt", 64'(bus.bubble_cnt_o), 64'd1);
    end
    bus.stall_i = 1'b0;
    step();
    chk("unstall_flush_valid", 64'(bus.ex_valid_o), 64'd0);
    chk("unstall_flush_ctrl", 64'(bus.ex_ctrl_o), 64'd0);
    chk("unstall_flush_cnt", 64'(bus.bubble_cnt_o), 64'd1);
    bus.flush_i = 1'b0;
    id_set(1'b1, C_LW, 5'd1, 5'd2, 5'd5, 32'd0);
    step();
    id_set(1'b1, C_ADD, 5'd3, 5'd5, 5'd4, 32'd0);
    #1;
    chk("ar_hazard", 64'(bus.hazard_stall_o), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 64'(bus.ex_valid_o), 64'd0);
    chk("ar_ctrl", 64'(bus.ex_ctrl_o), 64'd0);
    chk("ar_rd", 64'(bus.ex_rd_o), 64'd0);
    chk("ar_cnt", 64'(bus.bubble_cnt_o), 64'd0);
    chk("ar_hazard_off", 64'(bus.hazard_stall_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    id_set(1'b1, C_ADD, 5'd1, 5'd2, 5'd11, 32'h8000_0001);
    step();
    chk("post_rst_rd", 64'(bus.ex_rd_o), 64'd11);
    chk("post_rst_imm", 64'(bus.ex_imm_o), 64'h8000_0001);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register, directly downstream of the immediate generator and the decode stage.
- Captures the decoded control bits, the register-file read data, the 32-bit sign-extended immediate and the register indices each cycle.
- Contains load-use hazard detection: it inserts bubbles, requests an IF/ID + PC hold, and honours branch flush and a global memory stall.
- Counts inserted bubbles for performance reporting.

Parameters:
- XLEN, 32, datapath width (register data, immediate).
- REG_AW, 5, register index width.
- CNT_W, 32, width of the bubble counter.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- stall_i  in  1  global memory stall; freezes this register.
- flush_i  in  1  branch-taken flush from the branch unit.
- id_valid_i  in  1  decode slot holds a real instruction.
- id_ctrl_i  in  7  {RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, ALUOp[1:0]}.
- id_rs1_data_i, id_rs2_data_i  in  XLEN  register-file read data.
- id_imm_i  in  XLEN  signed immediate from the immediate generator.
- id_funct_i  in  10  {funct7, funct3}.
- id_rs1_i, id_rs2_i, id_rd_i  in  REG_AW  register indices.
- ex_valid_o  out  1  EX slot holds a real instruction.
- ex_ctrl_o  out  7  registered control bits.
- ex_rs1_data_o, ex_rs2_data_o, ex_imm_o  out  XLEN  registered data.
- ex_funct_o  out  10  registered funct fields.
- ex_rs1_o, ex_rs2_o, ex_rd_o  out  REG_AW  registered indices.
- hazard_stall_o  out  1  combinational; PC and IF/ID must hold.
- bubble_cnt_o  out  CNT_W  number of hazard bubbles inserted.

Behaviour:
- Reset (rst_i=0, async): all outputs and registers are 0.
  - ex_valid_o=0 and ex_ctrl_o=0, so the EX slot is a NOP.
  - bubble_cnt_o=0.
  - Reset mid-stall or mid-flush clears everything immediately; normal operation resumes on the first edge after rst_i rises.
- Hazard detect (combinational; hazard = hazard_stall_o):
  - hazard = ex_valid_o & ex_ctrl_o[MemRead] & (ex_rd_o != 0) & id_valid_i & ((ex_rd_o == id_rs1_i) | (ex_rd_o == id_rs2_i)).
  - hazard is forced to 0 when flush_i=1.
  - hazard is forced to 0 when stall_i=1.
  - x0 never triggers a hazard.
- Per-edge update, priority order:
  1. stall_i=1: hold all registers, including the counter.
  2. flush_i=1: load a bubble. ex_valid_o=0 and ex_ctrl_o=0; data and index fields are don't-care and are loaded as 0.
  3. hazard=1: load a bubble and increment bubble_cnt_o.
  4. otherwise: load all id_* inputs. ex_valid_o = id_valid_i, and ex_ctrl_o is forced to 0 when id_valid_i=0.
- Latency: one cycle from ID inputs to EX outputs. A load-use pair costs exactly one bubble.
  - The cycle after a bubble, ex_ctrl_o[MemRead]=0, so hazard deasserts automatically.
- Immediate and data fields pass through bit-exact; no re-extension.
- bubble_cnt_o wraps modulo 2^CNT_W; it counts hazard bubbles only, not flush bubbles.
- Simultaneous events:
  - flush_i with a hazard: flush wins, the counter is unchanged and hazard_stall_o=0.
  - stall_i with flush_i: hold. The branch unit keeps flush_i asserted until the stall clears.
- No combinational path from any id_* data input to any ex_* output.

Decomposition:
- Shared package cpu_pkg holds:
  - the ctrl bit positions: CTRL_REGWRITE=6, CTRL_MEMTOREG=5, CTRL_MEMREAD=4, CTRL_MEMWRITE=3, CTRL_ALUSRC=2, CTRL_ALUOP=1:0;
  - the ALUOp encodings (00 load/store, 01 branch, 10 R-type, 11 I-type);
  - CTRL_W=7 and the bubble constant (all-zero ctrl).
- One natural sub-module, hazard_detect: the combinational load-use comparator, reusable by the PC/IF-ID hold logic.

Test Plan:
- Reset: hold rst_i=0 with random inputs -> all outputs 0; release, id_ctrl_i=7'b1000010, rd=3, imm=32'hFFFFFFF8 -> next edge ex_ctrl_o=7'b1000010, ex_rd_o=3, ex_imm_o=32'hFFFFFFF8.
- Load-use: EX holds lw rd=5 (MemRead=1); ID add rs1=5 -> hazard_stall_o=1; next edge ex_valid_o=0 and bubble_cnt_o=1; next edge the add enters EX and hazard_stall_o=0.
- x0 and no-dependency cases: lw rd=0 followed by an instruction with rs1=0, and lw rd=5 followed by an instruction with rs1=6/rs2=7 -> hazard_stall_o=0 and the counter is unchanged in both.
- Flush priority: flush_i=1 in the same cycle as a load-use hazard -> hazard_stall_o=0; next edge ex_valid_o=0, ex_ctrl_o=0, bubble_cnt_o unchanged.
- Stall hold: stall_i=1 for 3 cycles with changing ID inputs and flush_i=1 -> EX outputs are constant and the counter is constant; on release with flush_i still 1 -> a bubble is loaded.
- Async reset mid-hazard: assert rst_i=0 between edges while hazard_stall_o=1 -> outputs go to 0 immediately, without waiting for a clock edge.
